// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and the FIFO level-width helper.
// The peripheral register block imports this too, so it packs the same
// level width into its status word that the FIFO drives.
package uart_pkg;

  localparam int UART_DATA_WIDTH    = 8;
  localparam int UART_TX_FIFO_DEPTH = 16;
  localparam int UART_TX_FIFO_AFULL = 12;

  // Width needed to hold an occupancy of 0..depth inclusive.
  function automatic int uart_level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: register array with one synchronous write port and an
// asynchronous read port. The FIFO needs first-word fall-through, so the read
// is combinational. Contents are never reset; the FIFO masks stale data itself.
module uart_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Store the written word at the write address.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: first-word fall-through transmit buffer between the
// peripheral register block and axi_uart. Holds pointers, occupancy, the
// registered almost-full flag and the optional dropped-write counter.
// Optional feature macro: UART_TX_FIFO_OVF_CNT_EN builds the saturating
// overflow counter; without it ovf_count_o is tied to zero.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH  = UART_DATA_WIDTH,
  parameter int DEPTH       = UART_TX_FIFO_DEPTH,
  parameter int AFULL_LEVEL = UART_TX_FIFO_AFULL
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               flush_i,
  input  logic [DATA_WIDTH-1:0]              s_axis_tdata,
  input  logic                               s_axis_tvalid,
  output logic                               s_axis_tready,
  output logic [DATA_WIDTH-1:0]              m_axis_tdata,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic [uart_level_width(DEPTH)-1:0] level_o,
  output logic                               afull_o,
  output logic [7:0]                         ovf_count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = uart_level_width(DEPTH);

  logic [AW-1:0]         wr_ptr_reg;
  logic [AW-1:0]         rd_ptr_reg;
  logic [LW-1:0]         count_reg;
  logic [LW-1:0]         count_next;
  logic                  afull_reg;
  logic                  primed_reg;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign full  = (count_reg == LW'(DEPTH));
  assign empty = (count_reg == '0);
  assign push  = s_axis_tvalid & ~full;
  assign pop   = m_axis_tready & ~empty;

  uart_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (push & ~flush_i),
    .waddr(wr_ptr_reg),
    .wdata(s_axis_tdata),
    .raddr(rd_ptr_reg),
    .rdata(mem_rdata)
  );

  // Next occupancy: flush wins, otherwise a lone push or lone pop moves it.
  always_comb begin
    count_next = count_reg;
    if (flush_i) begin
      count_next = '0;
    end else if (push && !pop) begin
      count_next = count_reg + 1'b1;
    end else if (pop && !push) begin
      count_next = count_reg - 1'b1;
    end
  end

  // Pointer, occupancy and almost-full state; almost-full tracks count_next so
  // both registers change on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      afull_reg  <= 1'b0;
      primed_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      afull_reg <= (count_next >= LW'(AFULL_LEVEL));
      if (flush_i) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (push) begin
          wr_ptr_reg <= wr_ptr_reg + 1'b1;
          primed_reg <= 1'b1;
        end
        if (pop) begin
          rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
      end
    end
  end

  // The array is not cleared by reset, so the head is forced to zero until
  // the first accepted write after reset.
  assign m_axis_tdata  = primed_reg ? mem_rdata : '0;
  assign m_axis_tvalid = ~empty;
  assign s_axis_tready = ~full;
  assign level_o       = count_reg;
  assign afull_o       = afull_reg;

`ifdef UART_TX_FIFO_OVF_CNT_EN
  logic [7:0] ovf_count_reg;

  // Count each cycle the peripheral strobes while full; saturate at 8'hFF.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_count_reg <= 8'h00;
    end else if (s_axis_tvalid && full && (ovf_count_reg != 8'hFF)) begin
      ovf_count_reg <= ovf_count_reg + 8'd1;
    end
  end

  assign ovf_count_o = ovf_count_reg;
`else
  assign ovf_count_o = 8'h00;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed self-checking bench for uart_tx_fifo.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_tx_fifo;

`ifdef UART_TX_FIFO_OVF_CNT_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       flush_i;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic [4:0] level_o;
  logic       afull_o;
  logic [7:0] ovf_count_o;

  int tests;
  int fails;
  logic [7:0] ovf_exp;

  uart_tx_fifo dut (
    .clk          (clk),
    .reset        (reset),
    .flush_i      (flush_i),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .level_o      (level_o),
    .afull_o      (afull_o),
    .ovf_count_o  (ovf_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    @(negedge clk);
    tests++; if (s_axis_tready !== 1'b1) begin fails++; $display("FAIL rst_tready got %b exp 1", s_axis_tready); end
    tests++; if (m_axis_tvalid !== 1'b0) begin fails++; $display("FAIL rst_tvalid got %b exp 0", m_axis_tvalid); end
    tests++; if (m_axis_tdata !== 8'h00) begin fails++; $display("FAIL rst_tdata got %h exp 00", m_axis_tdata); end
    tests++; if (level_o !== 5'd0) begin fails++; $display("FAIL rst_level got %0d exp 0", level_o); end
    tests++; if (afull_o !== 1'b0) begin fails++; $display("FAIL rst_afull got %b exp 0", afull_o); end
    tests++; if (ovf_count_o !== 8'h00) begin fails++; $display("FAIL rst_ovf got %h exp 00", ovf_count_o); end
    reset = 1'b0;
    $display("[TB] test_reset done");
  endtask

  task automatic test_order;
    @(negedge clk);
    tests++; if (m_axis_tvalid !== 1'b0) begin fails++; $display("FAIL ord_empty_tvalid got %b exp 0", m_axis_tvalid); end
    s_axis_tvalid = 1'b1; s_axis_tdata = 8'h41;
    @(negedge clk);
    tests++; if (m_axis_tvalid !== 1'b1) begin fails++; $display("FAIL ord_latency_tvalid got %b exp 1", m_axis_tvalid); end
    s_axis_tdata = 8'h42;
    @(negedge clk);
    s_axis_tdata = 8'h43;
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    tests++; if (level_o !== 5'd3) begin fails++; $display("FAIL ord_level got %0d exp 3", level_o); end
    tests++; if (m_axis_tdata !== 8'h41) begin fails++; $display("FAIL ord_head got %h exp 41", m_axis_tdata); end
    tests++; if (m_axis_tvalid !== 1'b1) begin fails++; $display("FAIL ord_tvalid got %b exp 1", m_axis_tvalid); end
    m_axis_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tests++; if (m_axis_tdata !== 8'h41 + 8'(i)) begin fails++; $display("FAIL ord_pop%0d got %h exp %h", i, m_axis_tdata, 8'h41 + 8'(i)); end
      @(negedge clk);
    end
    m_axis_tready = 1'b0;
    tests++; if (level_o !== 5'd0) begin fails++; $display("FAIL ord_end_level got %0d exp 0", level_o); end
    tests++; if (m_axis_tvalid !== 1'b0) begin fails++; $display("FAIL ord_end_tvalid got %b exp 0", m_axis_tvalid); end
    $display("[TB] test_order done");
  endtask

  task automatic test_full;
    for (int i = 0; i < 16; i++) begin
      tests++; if (level_o !== 5'(i)) begin fails++; $display("FAIL full_level%0d got %0d exp %0d", i, level_o, i); end
      tests++; if (afull_o !== (i >= 12)) begin fails++; $display("FAIL full_afull%0d got %b exp %b", i, afull_o, (i >= 12)); end
      tests++; if (s_axis_tready !== 1'b1) begin fails++; $display("FAIL full_tready%0d got %b exp 1", i, s_axis_tready); end
      s_axis_tvalid = 1'b1; s_axis_tdata = 8'h50 + 8'(i);
      @(negedge clk);
    end
    tests++; if (level_o !== 5'd16) begin fails++; $display("FAIL full_level16 got %0d exp 16", level_o); end
    tests++; if (s_axis_tready !== 1'b0) begin fails++; $display("FAIL full_tready16 got %b exp 0", s_axis_tready); end
    tests++; if (afull_o !== 1'b1) begin fails++; $display("FAIL full_afull16 got %b exp 1", afull_o); end
    s_axis_tdata = 8'hEE;
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    ovf_exp = OVF_EN ? 8'd1 : 8'd0;
    tests++; if (level_o !== 5'd16) begin fails++; $display("FAIL drop_level got %0d exp 16", level_o); end
    tests++; if (ovf_count_o !== ovf_exp) begin fails++; $display("FAIL drop_ovf got %0d exp %0d", ovf_count_o, ovf_exp); end
    $display("[TB] test_full done");
  endtask

  task automatic test_full_push_pop;
    tests++; if (m_axis_tdata !== 8'h50) begin fails++; $display("FAIL fpp_head got %h exp 50", m_axis_tdata); end
    s_axis_tvalid = 1'b1; s_axis_tdata = 8'hAA; m_axis_tready = 1'b1;
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    ovf_exp = OVF_EN ? 8'd2 : 8'd0;
    tests++; if (level_o !== 5'd15) begin fails++; $display("FAIL fpp_level got %0d exp 15", level_o); end
    tests++; if (s_axis_tready !== 1'b1) begin fails++; $display("FAIL fpp_tready got %b exp 1", s_axis_tready); end
    tests++; if (ovf_count_o !== ovf_exp) begin fails++; $display("FAIL fpp_ovf got %0d exp %0d", ovf_count_o, ovf_exp); end
    for (int i = 0; i < 15; i++) begin
      tests++; if (m_axis_tdata !== 8'h51 + 8'(i)) begin fails++; $display("FAIL fpp_drain%0d got %h exp %h", i, m_axis_tdata, 8'h51 + 8'(i)); end
      @(negedge clk);
    end
    m_axis_tready = 1'b0;
    tests++; if (level_o !== 5'd0) begin fails++; $display("FAIL fpp_end_level got %0d exp 0", level_o); end
    tests++; if (m_axis_tvalid !== 1'b0) begin fails++; $display("FAIL fpp_end_tvalid got %b exp 0", m_axis_tvalid); end
    $display("[TB] test_full_push_pop done");
  endtask

  task automatic test_back_to_back;
    logic [7:0] q[$];
    logic [7:0] exp_d;
    for (int i = 0; i < 5; i++) begin
      s_axis_tvalid = 1'b1; s_axis_tdata = 8'h10 + 8'(i); q.push_back(8'h10 + 8'(i));
      @(negedge clk);
    end
    m_axis_tready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tests++; if (level_o !== 5'd5) begin fails++; $display("FAIL b2b_level%0d got %0d exp 5", i, level_o); end
      tests++; if (m_axis_tdata !== q[0]) begin fails++; $display("FAIL b2b_head%0d got %h exp %h", i, m_axis_tdata, q[0]); end
      s_axis_tdata = 8'h15 + 8'(i);
      @(negedge clk);
      exp_d = q.pop_front();
      q.push_back(8'h15 + 8'(i));
    end
    s_axis_tvalid = 1'b0;
    tests++; if (level_o !== 5'd5) begin fails++; $display("FAIL b2b_after_level got %0d exp 5", level_o); end
    for (int i = 0; i < 5; i++) begin
      exp_d = q.pop_front();
      tests++; if (m_axis_tdata !== exp_d) begin fails++; $display("FAIL b2b_drain%0d got %h exp %h", i, m_axis_tdata, exp_d); end
      @(negedge clk);
    end
    m_axis_tready = 1'b0;
    tests++; if (level_o !== 5'd0) begin fails++; $display("FAIL b2b_end_level got %0d exp 0", level_o); end
    $display("[TB] test_back_to_back done");
  endtask

  task automatic test_flush;
    for (int i = 0; i < 7; i++) begin
      s_axis_tvalid = 1'b1; s_axis_tdata = 8'h70 + 8'(i);
      @(negedge clk);
    end
    tests++; if (level_o !== 5'd7) begin fails++; $display("FAIL fl_level7 got %0d exp 7", level_o); end
    flush_i = 1'b1; s_axis_tdata = 8'h99;
    @(negedge clk);
    flush_i = 1'b0; s_axis_tvalid = 1'b0;
    tests++; if (level_o !== 5'd0) begin fails++; $display("FAIL fl_level got %0d exp 0", level_o); end
    tests++; if (m_axis_tvalid !== 1'b0) begin fails++; $display("FAIL fl_tvalid got %b exp 0", m_axis_tvalid); end
    tests++; if (ovf_count_o !== ovf_exp) begin fails++; $display("FAIL fl_ovf_kept got %0d exp %0d", ovf_count_o, ovf_exp); end
    @(negedge clk);
    tests++; if (level_o !== 5'd0) begin fails++; $display("FAIL fl_level_hold got %0d exp 0", level_o); end
    s_axis_tvalid = 1'b1; s_axis_tdata = 8'hA5;
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    tests++; if (m_axis_tdata !== 8'hA5) begin fails++; $display("FAIL fl_new_head got %h exp a5", m_axis_tdata); end
    tests++; if (level_o !== 5'd1) begin fails++; $display("FAIL fl_new_level got %0d exp 1", level_o); end
    m_axis_tready = 1'b1;
    @(negedge clk);
    m_axis_tready = 1'b0;
    tests++; if (level_o !== 5'd0) begin fails++; $display("FAIL fl_end_level got %0d exp 0", level_o); end
    $display("[TB] test_flush done");
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 9; i++) begin
      s_axis_tvalid = 1'b1; s_axis_tdata = 8'h30 + 8'(i);
      @(negedge clk);
    end
    s_axis_tvalid = 1'b0;
    tests++; if (level_o !== 5'd9) begin fails++; $display("FAIL ar_level9 got %0d exp 9", level_o); end
    #1 reset = 1'b1;
    #1;
    tests++; if (s_axis_tready !== 1'b1) begin fails++; $display("FAIL ar_tready got %b exp 1", s_axis_tready); end
    tests++; if (m_axis_tvalid !== 1'b0) begin fails++; $display("FAIL ar_tvalid got %b exp 0", m_axis_tvalid); end
    tests++; if (m_axis_tdata !== 8'h00) begin fails++; $display("FAIL ar_tdata got %h exp 00", m_axis_tdata); end
    tests++; if (level_o !== 5'd0) begin fails++; $display("FAIL ar_level got %0d exp 0", level_o); end
    tests++; if (afull_o !== 1'b0) begin fails++; $display("FAIL ar_afull got %b exp 0", afull_o); end
    tests++; if (ovf_count_o !== 8'h00) begin fails++; $display("FAIL ar_ovf got %h exp 00", ovf_count_o); end
    @(negedge clk);
    reset = 1'b0;
    s_axis_tvalid = 1'b1; s_axis_tdata = 8'hC3;
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    tests++; if (m_axis_tdata !== 8'hC3) begin fails++; $display("FAIL ar_new_head got %h exp c3", m_axis_tdata); end
    tests++; if (m_axis_tvalid !== 1'b1) begin fails++; $display("FAIL ar_new_tvalid got %b exp 1", m_axis_tvalid); end
    tests++; if (level_o !== 5'd1) begin fails++; $display("FAIL ar_new_level got %0d exp 1", level_o); end
    $display("[TB] test_async_reset done");
  endtask

  initial begin
    tests = 0;
    fails = 0;
    ovf_exp = 8'h00;
    reset = 1'b1;
    flush_i = 1'b0;
    s_axis_tdata = 8'h00;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    test_reset();
    test_order();
    test_full();
    test_full_push_pop();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
